// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, 1/2 stops.
// Bit timing counts OVERSAMPLE ticks per bit from the shared baud prescaler.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;

  assign in_ready = (state_q == IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign bit_end  = tick && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          state_d    = START;
          cnt_d      = '0;
          idx_d      = '0;
          shift_d    = in_data;
          par_en_d   = cfg_parity_en;
          par_bit_d  = (^in_data) ^ cfg_parity_odd;
          two_stop_d = cfg_two_stop;
          stop2_d    = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      default: begin
        if (tick) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          unique case (state_q)
            START: begin
              state_d = DATA;
              idx_d   = '0;
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end
            DATA: begin
              if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                stop2_d = 1'b0;
                state_d = par_en_q ? PARITY : STOP;
                tx_d    = par_en_q ? par_bit_q : 1'b1;
              end else begin
                idx_d   = idx_q + IW'(1);
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
              end
            end
            PARITY: begin
              state_d = STOP;
              stop2_d = 1'b0;
              tx_d    = 1'b1;
            end
            default: begin
              // second stop bit is a repeat of STOP flagged by stop2
              if (two_stop_q && !stop2_q) begin
                stop2_d = 1'b1;
              end else begin
                state_d = IDLE;
                stop2_d = 1'b0;
                busy_d  = 1'b0;
              end
              tx_d = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected frame bits are queued
// when a word is offered and compared tick-by-tick as the line shifts out.
module tb_uart_tx_serializer;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DB-1:0] in_data = '0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_two_stop = 1'b0;
  logic          tx;
  logic          busy;

  int   checks = 0;
  int   passed = 0;
  bit   tick_run = 1'b0;
  int   ph = 0;
  logic exp_q[$];

  uart_tx_serializer #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // one tick every 4 clocks, changed just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_run) begin
        tick = (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        tick = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [DB-1:0] d, input bit pe,
                            input bit po, input bit ts);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ po);
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endtask

  // called at a negedge; returns just after the accepting posedge
  task automatic start(input logic [DB-1:0] d, input bit pe,
                       input bit po, input bit ts);
    in_valid = 1'b1;
    in_data = d;
    cfg_parity_en = pe;
    cfg_parity_odd = po;
    cfg_two_stop = ts;
    push_frame(d, pe, po, ts);
    chk("ready_at_offer", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic run_frame(input string tag, input bit keep,
                           input logic [DB-1:0] nd, input int chg_at,
                           input int abort_at);
    int n;
    int cyc;
    int errs;
    int bi;
    logic b;
    bi = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      n = 0;
      cyc = 0;
      errs = 0;
      while (n < OS && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (!keep) in_valid = 1'b0;
        if (keep && bi == 0 && cyc == 1) in_data = nd;
        if (bi == chg_at && cyc == 1) begin
          cfg_parity_en = 1'b1;
          cfg_two_stop = 1'b1;
          in_data = ~in_data;
        end
        if (tx !== b || busy !== 1'b1 || in_ready !== 1'b0) errs++;
        if (tick) n++;
        if (bi == abort_at && n == OS / 2) break;
      end
      if (cyc >= 400) errs++;
      chk($sformatf("%s bit%0d", tag, bi), errs, 0);
      if (bi == abort_at) begin
        exp_q.delete();
        return;
      end
      bi++;
    end
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    chk({tag, " end busy"}, busy, 0);
    chk({tag, " end ready"}, in_ready, 1);
    chk({tag, " end tx"}, tx, 1);
  endtask

  initial begin
    int g;
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset ready", in_ready, 1);
    rst_n = 1'b1;
    tick_run = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle tick tx", tx, 1);
    chk("idle tick busy", busy, 0);

    start(8'hA5, 0, 0, 0);
    run_frame("basic", 0, '0, -1, -1);

    start(8'h01, 1, 0, 1);
    run_frame("par_even", 0, '0, -1, -1);
    start(8'h01, 1, 1, 1);
    run_frame("par_odd", 0, '0, -1, -1);
    start(8'h00, 1, 0, 0);
    run_frame("par_zero", 0, '0, -1, -1);

    start(8'h3C, 0, 0, 0);
    run_frame("cfg_latch", 0, '0, 3, -1);
    start(8'h3C, 1, 0, 0);
    run_frame("cfg_next", 0, '0, -1, -1);

    start(8'h55, 0, 0, 0);
    run_frame("b2b_a", 1, 8'h0F, -1, -1);
    push_frame(8'h0F, 0, 0, 0);
    @(posedge clk);
    run_frame("b2b_b", 0, '0, -1, -1);

    start(8'hC3, 0, 0, 0);
    run_frame("rst_mid", 0, '0, -1, 4);
    rst_n = 1'b0;
    #1;
    chk("async rst tx", tx, 1);
    chk("async rst busy", busy, 0);
    chk("async rst ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post rst idle tx", tx, 1);
    start(8'h96, 0, 0, 0);
    run_frame("post_rst", 0, '0, -1, -1);

    g = 0;
    while (!tick && g < 10) begin
      @(negedge clk);
      g++;
    end
    start(8'hE1, 1, 1, 0);
    run_frame("tick_corner", 0, '0, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
